uart_rx_frame: RTL and testbench

- Parametrised UART receive framer; next generation of the team's 16550-style receiver FSM.
- Generalised in three ways:
  - configurable oversampling ratio
  - data width up to 4+2**WLS_W bits
  - 1/1.5/2 stop-bit checking
- Also adds start-bit glitch rejection and break hold-off.
- Sits between the baud generator (RXCLK enable) and the RX FIFO/line-status register.

---
 rtl/uart_rx_pkg.sv | 31 +++
 rtl/uart_rx_filter.sv | 26 ++
 rtl/uart_rx_frame.sv | 200 ++++++++++++++++++++
 tb/tb_uart_rx_frame.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the uart_rx_frame receiver.
// Holds the FSM state encoding and the expected-parity function.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP,
        STOP2,
        MWAIT
    } state_type;

    // Expected parity bit over the low nbits of data.
    function automatic logic exp_parity(
        input logic [63:0] data,
        input int          nbits,
        input logic        eps,
        input logic        sp
    );
        logic x;
        x = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (i < nbits) x ^= data[i];
        end
        if (sp) return ~eps;
        return eps ? x : ~x;
    endfunction

endpackage

// File: rtl/uart_rx_filter.sv
// Input conditioning for the UART receiver: 2-flop synchroniser followed
// by a 3-sample majority vote advanced on the RXCLK enable.
module uart_rx_filter (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic rxclk_i,
    input  logic sin_i,
    output logic fsin_o
);

    logic [1:0] sync_q;
    logic [2:0] hist_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= 2'b11;
            hist_q <= 3'b111;
        end else begin
            sync_q <= {sync_q[0], sin_i};
            if (rxclk_i) hist_q <= {hist_q[1:0], sync_q[1]};
        end
    end

    assign fsin_o = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);

endmodule

// File: rtl/uart_rx_frame.sv
// Parametrised UART receive framer (oversampled, 5..DATA_W data bits, 1/1.5/2 stop).
// Optional character timeout is compiled in with `define UART_RX_TIMEOUT_EN.
module uart_rx_frame
    import uart_rx_pkg::*;
#(
    parameter  int OVERSAMPLE   = 16,
    parameter  int WLS_W        = 2,
    parameter  int TIMEOUT_BITS = 40,
    localparam int DATA_W       = 4 + 2**WLS_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              RXCLK,
    input  logic              RXCLEAR,
    input  logic [WLS_W-1:0]  WLS,
    input  logic              STB,
    input  logic              PEN,
    input  logic              EPS,
    input  logic              SP,
    input  logic              SIN,
    output logic [DATA_W-1:0] DOUT,
    output logic              PE,
    output logic              FE,
    output logic              BI,
    output logic              RXFINISHED,
    output logic              TIMEOUT
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int NW = $clog2(DATA_W + 1);

    state_type         state_q, state_d;
    logic [CW-1:0]     baud_q;
    logic [NW-1:0]     bit_q;
    logic [DATA_W-1:0] data_q, dout_q;
    logic [WLS_W-1:0]  wls_q;
    logic              stb_q, pen_q, eps_q, sp_q, par_q, stop1_q;
    logic              pe_q, fe_q, bi_q, fin_q;

    logic fsin, at_half, at_full, last_bit, stop2_at, stop1_now;
    logic confirm, complete, pe_c, fe_c, bi_c;

    uart_rx_filter u_filter (
        .clk_i   (CLK),
        .rst_ni  (RST),
        .rxclk_i (RXCLK),
        .sin_i   (SIN),
        .fsin_o  (fsin)
    );

    assign at_half   = (baud_q == CW'(OVERSAMPLE/2 - 1));
    assign at_full   = (baud_q == CW'(OVERSAMPLE - 1));
    assign last_bit  = (bit_q == NW'(4) + NW'(wls_q));
    // Five data bits with STB set means 1.5 stop bits: sample mid-way.
    assign stop2_at  = (wls_q == '0) ? at_half : at_full;
    assign stop1_now = (state_q == STOP) ? fsin : stop1_q;

    always_ff @(posedge CLK) begin
        if (!RST) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (RXCLK) begin
            case (state_q)
                IDLE:    if (!fsin) state_d = START;
                START:   if (at_half) state_d = fsin ? IDLE : DATA;
                DATA:    if (at_full && last_bit) state_d = pen_q ? PAR : STOP;
                PAR:     if (at_full) state_d = STOP;
                STOP:    if (at_full) state_d = stb_q ? STOP2 : (fsin ? IDLE : MWAIT);
                STOP2:   if (stop2_at) state_d = (stop1_q && fsin) ? IDLE : MWAIT;
                MWAIT:   if (fsin) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
        if (RXCLEAR) state_d = IDLE;
    end

    always_comb begin
        confirm  = 1'b0;
        complete = 1'b0;
        fe_c     = 1'b0;
        if (RXCLK && !RXCLEAR) begin
            case (state_q)
                START: confirm = at_half && !fsin;
                STOP: begin
                    complete = at_full && !stb_q;
                    fe_c     = ~fsin;
                end
                STOP2: begin
                    complete = stop2_at;
                    fe_c     = ~stop1_q | ~fsin;
                end
                default: ;
            endcase
        end
        pe_c = pen_q && (par_q != exp_parity(64'(data_q), 5 + int'(wls_q), eps_q, sp_q));
        bi_c = (data_q == '0) && (!pen_q || !par_q) && !stop1_now;
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            baud_q  <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            wls_q   <= '0;
            stb_q   <= 1'b0;
            pen_q   <= 1'b0;
            eps_q   <= 1'b0;
            sp_q    <= 1'b0;
            par_q   <= 1'b0;
            stop1_q <= 1'b0;
            dout_q  <= '0;
            pe_q    <= 1'b0;
            fe_q    <= 1'b0;
            bi_q    <= 1'b0;
            fin_q   <= 1'b0;
        end else begin
            fin_q <= complete;
            if (complete) begin
                dout_q <= data_q;
                pe_q   <= pe_c;
                fe_q   <= fe_c;
                bi_q   <= bi_c;
            end
            if (confirm) begin
                data_q <= '0;
                bit_q  <= '0;
                wls_q  <= WLS;
                stb_q  <= STB;
                pen_q  <= PEN;
                eps_q  <= EPS;
                sp_q   <= SP;
            end
            if (RXCLEAR) begin
                baud_q <= '0;
                bit_q  <= '0;
            end else if (RXCLK) begin
                case (state_q)
                    IDLE, MWAIT: baud_q <= '0;
                    START:       baud_q <= at_half ? '0 : baud_q + CW'(1);
                    DATA: begin
                        baud_q <= baud_q + CW'(1);
                        if (at_full) begin
                            data_q[bit_q] <= fsin;
                            bit_q         <= last_bit ? '0 : bit_q + NW'(1);
                        end
                    end
                    PAR: begin
                        baud_q <= baud_q + CW'(1);
                        if (at_full) par_q <= fsin;
                    end
                    STOP: begin
                        baud_q <= baud_q + CW'(1);
                        if (at_full) stop1_q <= fsin;
                    end
                    default: baud_q <= baud_q + CW'(1);
                endcase
            end
        end
    end

    assign DOUT       = dout_q;
    assign PE         = pe_q;
    assign FE         = fe_q;
    assign BI         = bi_q;
    assign RXFINISHED = fin_q;

`ifdef UART_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_BITS + 1);

    logic          armed_q;
    logic [CW-1:0] to_tick_q;
    logic [TW-1:0] to_bits_q;

    // Counts whole idle bit-times after a completed frame, saturating.
    always_ff @(posedge CLK) begin
        if (!RST || RXCLEAR || confirm) begin
            armed_q   <= 1'b0;
            to_tick_q <= '0;
            to_bits_q <= '0;
        end else if (complete) begin
            armed_q   <= 1'b1;
            to_tick_q <= '0;
            to_bits_q <= '0;
        end else if (RXCLK && armed_q && state_q == IDLE) begin
            to_tick_q <= to_tick_q + CW'(1);
            if (to_tick_q == CW'(OVERSAMPLE - 1) && to_bits_q != TW'(TIMEOUT_BITS))
                to_bits_q <= to_bits_q + TW'(1);
        end
    end

    assign TIMEOUT = (to_bits_q == TW'(TIMEOUT_BITS));
`else
    // TIMEOUT_BITS only matters with the timeout built in; this is constant 0.
    assign TIMEOUT = (TIMEOUT_BITS < 0);
`endif

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed testbench for uart_rx_frame: a frame-level model predicts each
// completed word and flags; a per-cycle monitor compares the DUT against it.
module tb_uart_rx_frame;
    import uart_rx_pkg::*;

    localparam int OS = 16;

    logic       CLK = 1'b0;
    logic       RST, RXCLK, RXCLEAR, STB, PEN, EPS, SP, SIN;
    logic [1:0] WLS;
    logic [7:0] DOUT;
    logic       PE, FE, BI, RXFINISHED, TIMEOUT;

    typedef struct {
        logic [7:0] dout;
        logic       pe;
        logic       fe;
        logic       bi;
    } exp_t;

    exp_t exp_q[$];
    exp_t held;
    int   checks   = 0;
    int   errors   = 0;
    int   tick_cnt = 0;
    int   fin_cnt  = 0;
    int   fin_tick = 0;
    bit   chk_en   = 1'b0;

    uart_rx_frame #(.OVERSAMPLE(OS), .WLS_W(2), .TIMEOUT_BITS(40)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RXCLK      (RXCLK),
        .RXCLEAR    (RXCLEAR),
        .WLS        (WLS),
        .STB        (STB),
        .PEN        (PEN),
        .EPS        (EPS),
        .SP         (SP),
        .SIN        (SIN),
        .DOUT       (DOUT),
        .PE         (PE),
        .FE         (FE),
        .BI         (BI),
        .RXFINISHED (RXFINISHED),
        .TIMEOUT    (TIMEOUT)
    );

    always #5 CLK = ~CLK;

    initial begin
        RXCLK = 1'b0;
        forever begin
            repeat (3) @(posedge CLK);
            #1 RXCLK = 1'b1;
            @(posedge CLK);
            #1 RXCLK = 1'b0;
        end
    end

    always @(posedge CLK) if (RXCLK) tick_cnt <= tick_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            if (errors <= 20) $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
        end
    endtask

    // What a frame must produce, from the line contents and mode inputs alone.
    function automatic exp_t model_frame(input logic [7:0] d, input int nb, input logic pen,
                                         input logic eps, input logic sp, input logic par,
                                         input logic s1, input logic s2, input logic stb);
        exp_t e;
        int   ones;
        logic want;
        e.dout = 8'(int'(d) & ((1 << nb) - 1));
        ones   = $countones(e.dout);
        want   = sp ? ~eps : (eps ? (ones % 2 == 1) : (ones % 2 == 0));
        e.pe   = pen && (par != want);
        e.fe   = !s1 || (stb && !s2);
        e.bi   = (e.dout == 8'h00) && (!pen || !par) && !s1;
        return e;
    endfunction

    always @(negedge CLK) begin
        if (chk_en) begin
            if (RXFINISHED) begin
                fin_cnt++;
                fin_tick = tick_cnt;
                chk("finish_has_expectation", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) held = exp_q.pop_front();
                $display("frame %0d at tick %0d: DOUT=0x%02h PE=%b FE=%b BI=%b",
                         fin_cnt, tick_cnt, DOUT, PE, FE, BI);
            end
            chk("dout", 32'(DOUT), 32'(held.dout));
            chk("pe", 32'(PE), 32'(held.pe));
            chk("fe", 32'(FE), 32'(held.fe));
            chk("bi", 32'(BI), 32'(held.bi));
`ifndef UART_RX_TIMEOUT_EN
            chk("timeout_tied_low", 32'(TIMEOUT), 0);
`endif
        end
    end

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            while (RXCLK !== 1'b1) @(posedge CLK);
        end
        #2;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic s1,
                              input logic s2, output int st);
        int nb;
        nb = 5 + int'(WLS);
        exp_q.push_back(model_frame(d, nb, PEN, EPS, SP, par, s1, s2, STB));
        SIN = 1'b0;
        st  = tick_cnt;
        wait_ticks(OS);
        for (int i = 0; i < nb; i++) begin
            SIN = d[i];
            wait_ticks(OS);
        end
        if (PEN) begin
            SIN = par;
            wait_ticks(OS);
        end
        SIN = s1;
        wait_ticks(OS);
        if (STB) begin
            SIN = s2;
            wait_ticks(OS);
        end
        SIN = 1'b1;
        wait_ticks(2 * OS);
        chk("frame_consumed", 32'(exp_q.size()), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int st, n0, lat_a, lat_b, lat_c, lat_d, seen_start, beyond;
        logic [7:0] abort_d;
        RST = 1'b0; RXCLEAR = 1'b0; WLS = 2'd3; STB = 1'b0; PEN = 1'b0;
        EPS = 1'b0; SP = 1'b0; SIN = 1'b1;
        held.dout = 8'h00; held.pe = 1'b0; held.fe = 1'b0; held.bi = 1'b0;
        repeat (5) @(posedge CLK);
        #1;
        chk("reset_dout", 32'(DOUT), 0);
        chk("reset_flags", {28'd0, PE, FE, BI, RXFINISHED}, 0);
        chk("reset_timeout", 32'(TIMEOUT), 0);
        chk("reset_state", 32'(dut.state_q), 32'(IDLE));
        RST = 1'b1;
        chk_en = 1'b1;
        wait_ticks(2 * OS);

        // 8N1, 0xA5
        send_frame(8'hA5, 1'b0, 1'b1, 1'b1, st);
        chk("latency_8n1_window", 32'((fin_tick - st) >= 152 && (fin_tick - st) <= 164), 1);
        chk("a5_dout", 32'(DOUT), 32'h A5);
        chk("a5_flags", {29'd0, PE, FE, BI}, 0);

        // 5-bit parity cases on 0x15 (three ones)
        WLS = 2'd0; PEN = 1'b1; EPS = 1'b1; SP = 1'b0;
        send_frame(8'h15, 1'b0, 1'b1, 1'b1, st);
        chk("even_par0_dout", 32'(DOUT), 32'h15);
        chk("even_par0_pe", 32'(PE), 1);
        send_frame(8'h15, 1'b1, 1'b1, 1'b1, st);
        chk("even_par1_pe", 32'(PE), 0);
        SP = 1'b1;
        send_frame(8'h15, 1'b0, 1'b1, 1'b1, st);
        chk("stick_par0_pe", 32'(PE), 0);
        SP = 1'b0; EPS = 1'b0;
        send_frame(8'h15, 1'b1, 1'b1, 1'b1, st);
        chk("odd_par1_pe", 32'(PE), 1);

        // Start-bit glitch of 4 ticks
        n0 = fin_cnt; seen_start = 0; beyond = 0;
        SIN = 1'b0;
        for (int i = 0; i < 48; i++) begin
            if (i == 4) SIN = 1'b1;
            wait_ticks(1);
            if (dut.state_q == START) seen_start = 1;
            if (dut.state_q != START && dut.state_q != IDLE) beyond = 1;
        end
        chk("glitch_reached_start", 32'(seen_start), 1);
        chk("glitch_no_data_state", 32'(beyond), 0);
        chk("glitch_no_finish", 32'(fin_cnt - n0), 0);

        // Held break, 3 frame-times of 8E1
        WLS = 2'd3; PEN = 1'b1; EPS = 1'b1; SP = 1'b0; STB = 1'b0;
        n0 = fin_cnt;
        exp_q.push_back(model_frame(8'h00, 8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        SIN = 1'b0;
        wait_ticks(33 * OS);
        chk("break_one_finish", 32'(fin_cnt - n0), 1);
        chk("break_state_mwait", 32'(dut.state_q), 32'(MWAIT));
        chk("break_bi_fe", {30'd0, BI, FE}, 3);
        chk("break_dout", 32'(DOUT), 0);
        SIN = 1'b1;
        wait_ticks(2 * OS);
        chk("break_released_idle", 32'(dut.state_q), 32'(IDLE));
        send_frame(8'h3C, 1'b0, 1'b1, 1'b1, st);
        chk("after_break_dout", 32'(DOUT), 32'h3C);
        chk("after_break_flags", {29'd0, PE, FE, BI}, 0);

        // Stop-bit variants
        PEN = 1'b0; STB = 1'b1;
        send_frame(8'h81, 1'b0, 1'b1, 1'b0, st);
        chk("stop2_low_fe_bi", {30'd0, FE, BI}, 2);
        STB = 1'b0;
        send_frame(8'h55, 1'b0, 1'b1, 1'b1, st); lat_a = fin_tick - st;
        STB = 1'b1;
        send_frame(8'h55, 1'b0, 1'b1, 1'b1, st); lat_b = fin_tick - st;
        chk("two_stop_extra_ticks", 32'(lat_b - lat_a), 16);
        WLS = 2'd0; STB = 1'b0;
        send_frame(8'h0A, 1'b0, 1'b1, 1'b1, st); lat_c = fin_tick - st;
        STB = 1'b1;
        send_frame(8'h0A, 1'b0, 1'b1, 1'b1, st); lat_d = fin_tick - st;
        chk("one_and_half_stop_extra_ticks", 32'(lat_d - lat_c), 8);

        // RXCLEAR in data bit 4
        WLS = 2'd3; STB = 1'b0;
        send_frame(8'hA5, 1'b0, 1'b1, 1'b1, st);
        n0 = fin_cnt;
        abort_d = 8'h3C;
        SIN = 1'b0;
        wait_ticks(OS);
        for (int i = 0; i < 4; i++) begin
            SIN = abort_d[i];
            wait_ticks(OS);
        end
        SIN = abort_d[4];
        wait_ticks(OS / 2);
        repeat (3) @(posedge CLK);
        #1 RXCLEAR = 1'b1;
        @(posedge CLK);
        #1 RXCLEAR = 1'b0;
        chk("clear_state_idle", 32'(dut.state_q), 32'(IDLE));
        chk("clear_baud_zero", 32'(dut.baud_q), 0);
        SIN = 1'b1;
        wait_ticks(4 * OS);
        chk("clear_no_finish", 32'(fin_cnt - n0), 0);
        chk("clear_dout_kept", 32'(DOUT), 32'hA5);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b1, st);
        chk("after_clear_dout", 32'(DOUT), 32'h5A);

`ifdef UART_RX_TIMEOUT_EN
        while (tick_cnt < fin_tick + 630) wait_ticks(1);
        chk("timeout_not_yet", 32'(TIMEOUT), 0);
        while (tick_cnt < fin_tick + 660) wait_ticks(1);
        chk("timeout_set", 32'(TIMEOUT), 1);
        fork
            send_frame(8'h69, 1'b0, 1'b1, 1'b1, st);
            begin
                wait_ticks(24);
                chk("timeout_cleared_by_start", 32'(TIMEOUT), 0);
            end
        join
`endif

        // Reset in the middle of a frame
        SIN = 1'b0;
        wait_ticks(3 * OS);
        chk_en = 1'b0;
        RST = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("midreset_dout", 32'(DOUT), 0);
        chk("midreset_flags", {28'd0, PE, FE, BI, RXFINISHED}, 0);
        chk("midreset_state", 32'(dut.state_q), 32'(IDLE));
        held.dout = 8'h00; held.pe = 1'b0; held.fe = 1'b0; held.bi = 1'b0;
        exp_q.delete();
        SIN = 1'b1;
        RST = 1'b1;
        chk_en = 1'b1;
        n0 = fin_cnt;
        wait_ticks(4 * OS);
        chk("midreset_no_partial", 32'(fin_cnt - n0), 0);
        send_frame(8'h96, 1'b0, 1'b1, 1'b1, st);
        chk("final_dout", 32'(DOUT), 32'h96);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
